// File: rtl/uart_pkg.sv
// Shared register map, status/control bit positions and FSM encodings
// for the APB UART with TX/RX FIFOs.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned DIV_W1 = DIV_W + 1;

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_CTRL   = 8'h02;
  localparam logic [7:0] ADDR_DIV_LO = 8'h03;
  localparam logic [7:0] ADDR_DIV_HI = 8'h04;

  localparam int unsigned ST_TX_EMPTY  = 0;
  localparam int unsigned ST_TX_FULL   = 1;
  localparam int unsigned ST_RX_EMPTY  = 2;
  localparam int unsigned ST_RX_FULL   = 3;
  localparam int unsigned ST_RX_OVR    = 4;
  localparam int unsigned ST_FRAME_ERR = 5;
  localparam int unsigned ST_TX_BUSY   = 6;

  localparam int unsigned CTRL_RX_IE = 0;
  localparam int unsigned CTRL_TX_IE = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // STATUS register image; last field is bit 0
  typedef struct packed {
    logic tx_busy;
    logic frame_err;
    logic rx_ovr;
    logic rx_full;
    logic rx_empty;
    logic tx_full;
    logic tx_empty;
  } status_t;

endpackage

// File: rtl/apb_uart_fifo_if.sv
// APB3 slave bus bundle for the UART register block.
interface apb_uart_fifo_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pselx;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output paddr, pselx, penable, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pselx, penable, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; full is judged before any same-cycle pop, so a push
// into a full FIFO is dropped even when a pop happens alongside it.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_nx;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata_c = mem[rd_ptr];

  always_comb begin
    count_nx = count;
    if (do_push && !do_pop) begin
      count_nx = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_nx = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nx;
      full  <= (count_nx == CW'(DEPTH));
      empty <= (count_nx == '0);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/apb_uart_fifo.sv
// APB-attached 8N1 UART with TX and RX FIFOs, programmable baud divisor
// and a level interrupt.
module apb_uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned      ADDR_WIDTH  = 8,
  parameter int unsigned      DATA_WIDTH  = 8,
  parameter int unsigned      FIFO_DEPTH  = 8,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd867
) (
  input  logic                  pclk,
  input  logic                  prst,
  apb_uart_fifo_if.slave        apb,
  input  logic                  rx,
  output logic                  tx,
  output logic                  irq
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // Register file
  logic [1:0]        ctrl;
  logic [7:0]        div_lo;
  logic [7:0]        div_hi;
  logic              rx_ovr;
  logic              frame_err;
  logic [DIV_W-1:0]  div;

  // FIFO hookup
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [BYTE_W-1:0] tx_head_c, rx_head_c, rx_shift;
  logic [CW-1:0]     tx_count, rx_count;
  logic              unused_levels;

  // APB decode
  logic              access, addr_ok, bus_err;
  logic              hit_data, hit_status, hit_ctrl, hit_div_lo, hit_div_hi;
  logic              wr_en, rd_en;
  logic [7:0]        wbyte;
  logic [7:0]        rd_byte_c;
  status_t           status;

  // TX engine
  tx_state_e         tx_state, tx_state_nx;
  logic [DIV_W-1:0]  tx_cnt, tx_bit_div;
  logic [2:0]        tx_bit;
  logic [BYTE_W-1:0] tx_shift;
  logic              tx_bit_end_c, tx_c, tx_busy;

  // RX engine
  rx_state_e         rx_state, rx_state_nx;
  logic [1:0]        rx_sync;
  logic              rx_s, rx_prev, rx_fall_c;
  logic [DIV_W-1:0]  rx_cnt, rx_bit_div;
  logic [DIV_W1-1:0] rx_half_c;
  logic [2:0]        rx_bit;
  logic              rx_half_end_c, rx_bit_end_c;
  logic              ovr_set, ferr_set;

  assign div   = {div_hi, div_lo};
  assign wbyte = apb.pwdata[7:0];

  assign access     = apb.pselx & apb.penable;
  assign hit_data   = (apb.paddr == ADDR_WIDTH'(ADDR_DATA));
  assign hit_status = (apb.paddr == ADDR_WIDTH'(ADDR_STATUS));
  assign hit_ctrl   = (apb.paddr == ADDR_WIDTH'(ADDR_CTRL));
  assign hit_div_lo = (apb.paddr == ADDR_WIDTH'(ADDR_DIV_LO));
  assign hit_div_hi = (apb.paddr == ADDR_WIDTH'(ADDR_DIV_HI));
  assign addr_ok    = hit_data | hit_status | hit_ctrl | hit_div_lo | hit_div_hi;

  assign bus_err = access & (~addr_ok
                           | (hit_data &  apb.pwrite & tx_full)
                           | (hit_data & ~apb.pwrite & rx_empty));
  assign wr_en   = access &  apb.pwrite & ~bus_err;
  assign rd_en   = access & ~apb.pwrite & ~bus_err;
  assign tx_push = wr_en & hit_data;
  assign rx_pop  = rd_en & hit_data;

  assign status = '{tx_busy:   tx_busy,
                    frame_err: frame_err,
                    rx_ovr:    rx_ovr,
                    rx_full:   rx_full,
                    rx_empty:  rx_empty,
                    tx_full:   tx_full,
                    tx_empty:  tx_empty};

  // Read mux; zero outside a successful read access
  always_comb begin
    rd_byte_c = '0;
    if (rd_en) begin
      if (hit_data)        rd_byte_c = rx_head_c;
      else if (hit_status) rd_byte_c = {1'b0, status};
      else if (hit_ctrl)   rd_byte_c = {6'b0, ctrl};
      else if (hit_div_lo) rd_byte_c = div_lo;
      else if (hit_div_hi) rd_byte_c = div_hi;
    end
  end

  assign apb.pready  = 1'b1;
  assign apb.prdata  = DATA_WIDTH'(rd_byte_c);
  assign apb.pslverr = bus_err;

  // FIFO levels are not part of the register map
  assign unused_levels = ^{tx_count, rx_count};

  // Control/status registers and interrupt; sticky-bit sets win over clears
  always_ff @(posedge pclk) begin
    if (prst) begin
      ctrl      <= '0;
      div_lo    <= DEFAULT_DIV[7:0];
      div_hi    <= DEFAULT_DIV[15:8];
      rx_ovr    <= 1'b0;
      frame_err <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (wr_en && hit_ctrl)   ctrl   <= wbyte[1:0];
      if (wr_en && hit_div_lo) div_lo <= wbyte;
      if (wr_en && hit_div_hi) div_hi <= wbyte;
      if (wr_en && hit_status && wbyte[ST_RX_OVR])    rx_ovr    <= 1'b0;
      if (wr_en && hit_status && wbyte[ST_FRAME_ERR]) frame_err <= 1'b0;
      if (ovr_set)  rx_ovr    <= 1'b1;
      if (ferr_set) frame_err <= 1'b1;
      irq <= (ctrl[CTRL_RX_IE] & ~rx_empty) | (ctrl[CTRL_TX_IE] & tx_empty);
    end
  end

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (pclk),
    .rst     (prst),
    .push    (tx_push),
    .pop     (tx_pop),
    .wdata   (wbyte),
    .rdata_c (tx_head_c),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (pclk),
    .rst     (prst),
    .push    (rx_push),
    .pop     (rx_pop),
    .wdata   (rx_shift),
    .rdata_c (rx_head_c),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  // ---------------- TX ----------------
  assign tx_bit_end_c = (tx_cnt == tx_bit_div);

  always_ff @(posedge pclk) begin
    if (prst) tx_state <= TX_IDLE;
    else      tx_state <= tx_state_nx;
  end

  always_comb begin
    tx_state_nx = tx_state;
    case (tx_state)
      TX_IDLE:  if (!tx_empty)                     tx_state_nx = TX_START;
      TX_START: if (tx_bit_end_c)                  tx_state_nx = TX_DATA;
      TX_DATA:  if (tx_bit_end_c && tx_bit == 3'd7) tx_state_nx = TX_STOP;
      TX_STOP:  if (tx_bit_end_c)                  tx_state_nx = TX_IDLE;
      default:                                     tx_state_nx = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_pop  = 1'b0;
    tx_c    = 1'b1;
    tx_busy = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_busy = 1'b0;
        tx_pop  = ~tx_empty;
      end
      TX_START: tx_c = 1'b0;
      TX_DATA:  tx_c = tx_shift[0];
      default:  tx_c = 1'b1;
    endcase
  end

  // Bit timer; divisor is re-latched at every bit boundary
  always_ff @(posedge pclk) begin
    if (prst) begin
      tx         <= 1'b1;
      tx_cnt     <= '0;
      tx_bit_div <= DEFAULT_DIV;
      tx_bit     <= '0;
      tx_shift   <= '0;
    end else begin
      tx <= tx_c;
      if (tx_state == TX_IDLE) begin
        tx_cnt     <= '0;
        tx_bit     <= '0;
        tx_bit_div <= div;
        if (tx_pop) tx_shift <= tx_head_c;
      end else if (tx_bit_end_c) begin
        tx_cnt     <= '0;
        tx_bit_div <= div;
        if (tx_state == TX_DATA) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 3'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + DIV_W'(1);
      end
    end
  end

  // ---------------- RX ----------------
  assign rx_s          = rx_sync[1];
  assign rx_fall_c     = rx_prev & ~rx_s;
  assign rx_half_c     = ({1'b0, rx_bit_div} + DIV_W1'(1)) >> 1;
  assign rx_half_end_c = (({1'b0, rx_cnt} + DIV_W1'(1)) >= rx_half_c);
  assign rx_bit_end_c  = (rx_cnt == rx_bit_div);

  always_ff @(posedge pclk) begin
    if (prst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) rx_state <= RX_IDLE;
    else      rx_state <= rx_state_nx;
  end

  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall_c)     rx_state_nx = RX_START;
      RX_START: if (rx_half_end_c) rx_state_nx = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_end_c && rx_bit == 3'd7) rx_state_nx = RX_STOP;
      RX_STOP:  if (rx_bit_end_c)  rx_state_nx = RX_IDLE;
      default:                     rx_state_nx = RX_IDLE;
    endcase
  end

  // Stop-bit verdict: framing error beats overrun
  always_comb begin
    rx_push  = 1'b0;
    ovr_set  = 1'b0;
    ferr_set = 1'b0;
    if (rx_state == RX_STOP && rx_bit_end_c) begin
      if (!rx_s)        ferr_set = 1'b1;
      else if (rx_full) ovr_set  = 1'b1;
      else              rx_push  = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      rx_cnt     <= '0;
      rx_bit_div <= DEFAULT_DIV;
      rx_bit     <= '0;
      rx_shift   <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt     <= '0;
          rx_bit     <= '0;
          rx_bit_div <= div;
        end
        RX_START: begin
          if (rx_half_end_c) begin
            rx_cnt     <= '0;
            rx_bit_div <= div;
          end else begin
            rx_cnt <= rx_cnt + DIV_W'(1);
          end
        end
        default: begin
          if (rx_bit_end_c) begin
            rx_cnt     <= '0;
            rx_bit_div <= div;
            if (rx_state == RX_DATA) begin
              rx_shift <= {rx_s, rx_shift[7:1]};
              rx_bit   <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + DIV_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed bench for apb_uart_fifo: register access, TX waveform, loopback,
// FIFO full/overrun, framing error, interrupt and mid-frame reset.
module tb_apb_uart_fifo;
  import uart_pkg::*;

  localparam int BIT_CYC = 4;

  logic pclk = 1'b0;
  logic prst = 1'b1;
  logic rx_drv = 1'b1;
  logic loop = 1'b0;
  logic rx, tx, irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  d, d2, byte_v;
  logic        e, e2, ok, saw_low;
  logic [39:0] got, expv;
  logic [9:0]  errs;

  apb_uart_fifo_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  apb_uart_fifo dut (
    .pclk (pclk),
    .prst (prst),
    .apb  (bus),
    .rx   (rx),
    .tx   (tx),
    .irq  (irq)
  );

  assign rx = loop ? tx : rx_drv;

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] v, output logic err);
    @(posedge pclk); #1;
    bus.paddr = a; bus.pwrite = 1'b1; bus.pwdata = v;
    bus.pselx = 1'b1; bus.penable = 1'b0;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    #1 err = bus.pslverr;
    @(posedge pclk); #1;
    bus.pselx = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] v, output logic err);
    @(posedge pclk); #1;
    bus.paddr = a; bus.pwrite = 1'b0;
    bus.pselx = 1'b1; bus.penable = 1'b0;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    #1 begin v = bus.prdata; err = bus.pslverr; end
    @(posedge pclk); #1;
    bus.pselx = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic wait_tx_low(output logic found);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (tx === 1'b0) found = 1'b1;
      else begin @(posedge pclk); #1; end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge pclk); #1;
    rx_drv = 1'b0;
    repeat (BIT_CYC) @(posedge pclk); #1;
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (BIT_CYC) @(posedge pclk); #1;
    end
    rx_drv = stop;
    repeat (BIT_CYC) @(posedge pclk); #1;
    rx_drv = 1'b1;
    repeat (BIT_CYC) @(posedge pclk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.paddr = '0; bus.pselx = 1'b0; bus.penable = 1'b0;
    bus.pwrite = 1'b0; bus.pwdata = '0;

    // Reset state
    repeat (3) @(posedge pclk); #1;
    prst = 1'b0;
    check("rst_tx", tx, 1'b1);
    check("rst_irq", irq, 1'b0);
    check("pready", bus.pready, 1'b1);
    check("idle_prdata", bus.prdata, 8'h00);
    check("idle_pslverr", bus.pslverr, 1'b0);
    apb_read(ADDR_STATUS, d, e);  check("rst_status", {e, d}, {1'b0, 8'h05});
    apb_read(ADDR_DIV_LO, d, e);  check("rst_div_lo", {e, d}, {1'b0, 8'h63});
    apb_read(ADDR_DIV_HI, d, e);  check("rst_div_hi", {e, d}, {1'b0, 8'h03});
    apb_read(ADDR_CTRL, d, e);    check("rst_ctrl", {e, d}, {1'b0, 8'h00});

    // Unmapped addresses
    apb_read(8'h05, d, e);        check("bad_rd_05", {e, d}, {1'b1, 8'h00});
    apb_read(8'hFF, d, e);        check("bad_rd_ff", {e, d}, {1'b1, 8'h00});
    apb_write(8'h07, 8'hFF, e);   check("bad_wr_07", e, 1'b1);

    // DIV = 3 -> 4 clocks per bit
    apb_write(ADDR_DIV_LO, 8'h03, e);
    apb_write(ADDR_DIV_HI, 8'h00, e);
    apb_read(ADDR_DIV_LO, d, e);  check("div_lo_wr", {e, d}, {1'b0, 8'h03});

    // TX waveform for 0xA5
    byte_v = 8'hA5;
    for (int c = 0; c < 40; c++)
      expv[c] = (c < 4) ? 1'b0 : (c >= 36) ? 1'b1 : byte_v[c/4 - 1];
    apb_write(ADDR_DATA, 8'hA5, e); check("tx_wr_err", e, 1'b0);
    wait_tx_low(ok);                check("tx_start_seen", ok, 1'b1);
    fork
      begin
        for (int c = 0; c < 40; c++) begin
          got[c] = tx;
          @(posedge pclk); #1;
        end
      end
      begin
        repeat (10) @(posedge pclk);
        apb_read(ADDR_STATUS, d2, e2);
      end
    join
    check("tx_frame_a5", got, expv);
    check("tx_busy_mid", {e2, d2}, {1'b0, 8'h45});
    apb_read(ADDR_STATUS, d, e);  check("tx_done_status", {e, d}, {1'b0, 8'h05});

    // tx_ie interrupt on empty TX FIFO
    apb_write(ADDR_CTRL, 8'h02, e);
    @(posedge pclk); #1;          check("irq_tx_ie", irq, 1'b1);
    apb_write(ADDR_CTRL, 8'h00, e);
    @(posedge pclk); #1;          check("irq_off", irq, 1'b0);

    // Loopback 0x3C
    loop = 1'b1;
    apb_write(ADDR_DATA, 8'h3C, e);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      apb_read(ADDR_STATUS, d, e);
      if (d[ST_RX_EMPTY] == 1'b0) ok = 1'b1;
    end
    check("loop_rx_arrived", ok, 1'b1);
    apb_read(ADDR_DATA, d, e);    check("loop_rd", {e, d}, {1'b0, 8'h3C});
    apb_read(ADDR_DATA, d, e);    check("loop_rd_empty", {e, d}, {1'b1, 8'h00});
    repeat (10) @(posedge pclk); #1;
    loop = 1'b0;

    // TX FIFO fill with a stalled line
    apb_write(ADDR_DIV_LO, 8'hFF, e);
    apb_write(ADDR_DIV_HI, 8'hFF, e);
    for (int k = 0; k < 9; k++) begin
      apb_write(ADDR_DATA, 8'h10 + 8'(k), e);
      errs[k] = e;
    end
    apb_read(ADDR_STATUS, d, e);  check("txf_status_full", {e, d}, {1'b0, 8'h46});
    apb_write(ADDR_DATA, 8'h19, e);
    errs[9] = e;
    check("txf_errs", errs, 10'b10_0000_0000);
    apb_read(ADDR_STATUS, d, e);  check("txf_status_after", {e, d}, {1'b0, 8'h46});

    prst = 1'b1; @(posedge pclk); #1; prst = 1'b0;
    apb_read(ADDR_STATUS, d, e);  check("txf_rst_status", {e, d}, {1'b0, 8'h05});
    apb_write(ADDR_DIV_LO, 8'h03, e);
    apb_write(ADDR_DIV_HI, 8'h00, e);

    // RX overrun: nine frames, no reads
    for (int k = 1; k <= 9; k++) send_frame(8'(8'h11 * k), 1'b1);
    apb_read(ADDR_STATUS, d, e);  check("ovr_status", {e, d}, {1'b0, 8'h19});
    for (int k = 1; k <= 8; k++) begin
      apb_read(ADDR_DATA, d, e);
      check($sformatf("ovr_rd%0d", k), {e, d}, {1'b0, 8'(8'h11 * k)});
    end
    apb_read(ADDR_DATA, d, e);    check("ovr_rd9_lost", {e, d}, {1'b1, 8'h00});
    apb_read(ADDR_STATUS, d, e);  check("ovr_drained", {e, d}, {1'b0, 8'h15});
    apb_write(ADDR_STATUS, 8'h2F, e);
    apb_read(ADDR_STATUS, d, e);  check("ovr_keep", {e, d}, {1'b0, 8'h15});
    apb_write(ADDR_STATUS, 8'h10, e);
    apb_read(ADDR_STATUS, d, e);  check("ovr_clear", {e, d}, {1'b0, 8'h05});

    // Framing error with rx_ie
    apb_write(ADDR_CTRL, 8'h01, e);
    @(posedge pclk); #1;          check("ferr_irq_before", irq, 1'b0);
    send_frame(8'h55, 1'b0);
    apb_read(ADDR_STATUS, d, e);  check("ferr_status", {e, d}, {1'b0, 8'h25});
    check("ferr_irq", irq, 1'b0);
    send_frame(8'h5A, 1'b1);
    check("rx_irq", irq, 1'b1);
    apb_read(ADDR_DATA, d, e);    check("rx_after_ferr", {e, d}, {1'b0, 8'h5A});
    @(posedge pclk); #1;          check("rx_irq_clear", irq, 1'b0);
    apb_write(ADDR_STATUS, 8'h20, e);
    apb_read(ADDR_STATUS, d, e);  check("ferr_clear", {e, d}, {1'b0, 8'h05});
    apb_write(ADDR_CTRL, 8'h00, e);

    // Reset in the middle of TX data bit 4
    apb_write(ADDR_DATA, 8'h00, e);
    wait_tx_low(ok);              check("mid_start_seen", ok, 1'b1);
    repeat (21) @(posedge pclk); #1;
    check("mid_bit4_low", tx, 1'b0);
    prst = 1'b1; @(posedge pclk); #1; prst = 1'b0;
    check("mid_rst_tx", tx, 1'b1);
    saw_low = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (tx !== 1'b1) saw_low = 1'b1;
      @(posedge pclk); #1;
    end
    check("mid_rst_tx_idle", saw_low, 1'b0);
    apb_read(ADDR_STATUS, d, e);  check("mid_rst_status", {e, d}, {1'b0, 8'h05});
    apb_read(ADDR_DIV_LO, d, e);  check("mid_rst_div_lo", {e, d}, {1'b0, 8'h63});
    apb_read(ADDR_DIV_HI, d, e);  check("mid_rst_div_hi", {e, d}, {1'b0, 8'h03});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_uart_fifo.md
APB_UART_FIFO -- requirements
Module: apb_uart_fifo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, APB data width; UART frames are fixed at 8 data bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, entries per TX and RX FIFO; must be a power of 2 and at least 2.
REQ-004 SHALL have parameter DEFAULT_DIV, default 16'd867, reset value of the baud divisor.
REQ-005 SHALL have ports: pclk in 1, the only clock; prst in 1, synchronous active-high reset.
REQ-006 SHALL have ports: paddr in ADDR_WIDTH; pselx in 1; penable in 1; pwrite in 1; pwdata in DATA_WIDTH.
REQ-007 SHALL have ports: pready out 1; prdata out DATA_WIDTH; pslverr out 1.
REQ-008 SHALL have ports: rx in 1, serial input, asynchronous to pclk; tx out 1, serial output; irq out 1, level interrupt.

Function
REQ-009 SHALL hold pready at 1 (zero wait states); an access is pselx&penable; prdata and pslverr are valid only during an access, else 0.
REQ-010 SHALL decode the register map on paddr:
- 0x00 DATA: write pushes the TX FIFO; read pops the RX FIFO.
- 0x01 STATUS: b0 tx_empty, b1 tx_full, b2 rx_empty, b3 rx_full, b4 rx_ovr, b5 frame_err, b6 tx_busy.
- 0x02 CTRL, RW: b0 rx_ie, b1 tx_ie.
- 0x03 DIV_LO, RW.
- 0x04 DIV_HI, RW.
REQ-011 SHALL assert pslverr, with no state change and prdata=0, on: any other address; a DATA write when the TX FIFO is full (byte dropped); a DATA read when the RX FIFO is empty.
REQ-012 SHALL pop the RX FIFO exactly once per DATA read access; prdata shows the head entry in that cycle.
REQ-013 SHALL clear rx_ovr/frame_err on a STATUS write with 1 in the matching bit; 0 bits and the other STATUS bits are ignored.
REQ-014 SHALL make each FIFO push only when not full and pop only when not empty, with full evaluated before any same-cycle pop; a simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
REQ-015 SHALL make one bit period DIV+1 pclk cycles, DIV = {DIV_HI, DIV_LO}; a DIV write takes effect at the next bit boundary.
REQ-016 SHALL implement the TX FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE.
- From IDLE, it leaves in the cycle after the TX FIFO becomes non-empty and pops one byte.
- tx_busy=1 outside IDLE.
- tx=1 in IDLE.
REQ-017 SHALL pass rx through a 2-flop synchroniser, then run the RX FSM IDLE->START->DATA->STOP.
- A 1->0 edge starts a frame.
- Start is re-checked after (DIV+1)/2 cycles; if high, return to IDLE.
- Each following bit is sampled every DIV+1 cycles.
REQ-018 SHALL handle the RX stop bit as follows:
- Stop sampled low: set frame_err and discard the byte.
- Else, RX FIFO full: set rx_ovr and discard the byte.
- Else: push the byte.
REQ-019 SHALL drive irq = (rx_ie & ~rx_empty) | (tx_ie & tx_empty), registered, 1-cycle latency.

Reset
REQ-020 SHALL, when prst=1 at a pclk edge, set tx=1, irq=0, both FIFOs empty, both FSMs IDLE, CTRL=0, DIV=DEFAULT_DIV, rx_ovr=frame_err=0; this applies mid-frame, and the partial frame is abandoned.
REQ-021 SHALL set the synchroniser flops to 1 on reset.

Structure
REQ-022 SHALL place the register offsets, STATUS/CTRL bit indices and the FSM state encodings in the shared package uart_pkg.
REQ-023 SHALL implement both FIFOs as two instances of one sub-module, sync_fifo, parametrised by width and depth, with full, empty and count outputs.

Verification (DIV=3, i.e. 4 clk/bit)
REQ-024 SHALL cover: write DATA=0xA5 -> tx low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; tx_busy high for 40 cycles.
REQ-025 SHALL cover: tx looped to rx, write 0x3C -> rx_empty drops after the frame; DATA read returns 0x3C; a second read gives pslverr=1, prdata=0.
REQ-026 SHALL cover: with the TX line stalled by DIV=0xFFFF, write 10 bytes -> 1st byte popped into TX, 2nd-9th fill the FIFO (tx_full=1), 10th gives pslverr=1 and is dropped.
REQ-027 SHALL cover: drive 9 frames into rx with no reads -> rx_full=1, rx_ovr=1, the 9th byte is lost; 8 reads return bytes 1-8; a STATUS write of 0x10 clears rx_ovr.
REQ-028 SHALL cover: an rx frame with the stop bit low -> frame_err=1, rx_empty stays 1; with rx_ie=1, irq stays 0.
REQ-029 SHALL cover: prst=1 for one cycle in the middle of TX data bit 4 -> next cycle tx=1, tx_empty=1, DIV=DEFAULT_DIV.
